// File: rtl/clock_cpu_cpu_debug_mem_access.sv
// Debug-monitor memory access engine: turns JTAG command strobes into single
// word reads/writes on a memory master port, tracks the monitor address/data
// registers and reports ready/error status back to the debugger.
module clock_cpu_cpu_debug_mem_access #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    input  logic              mem_waitrequest
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [CNT_W-1:0]  tmo_cnt_next;
    logic [31:0]       mon_d_next;
    logic [ADDR_W-1:0] mon_a_next;
    logic              ready_next;
    logic              error_next;
    logic              any_strobe;
    logic              rd_done;
    logic              wr_done;
    logic              jdo_unused;

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // Only part of the JTAG word carries meaning for this block.
    assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

    // The request is a pure function of state so it cannot change while stalled.
    assign mem_address   = MonAReg;
    assign mem_read      = (state == RD_REQ);
    assign mem_write     = (state == WR_REQ);
    assign mem_writedata = (state == WR_REQ) ? MonDReg : 32'd0;

    // Completion detection: a read finishes when data arrives after (or with)
    // acceptance; a write finishes as soon as the slave stops stalling.
    always_comb begin
        rd_done = 1'b0;
        wr_done = 1'b0;
        case (state)
            RD_REQ:  rd_done = !mem_waitrequest && mem_readdatavalid;
            RD_WAIT: rd_done = mem_readdatavalid;
            WR_REQ:  wr_done = !mem_waitrequest;
            default: ;
        endcase
    end

    // Command decode, access sequencing, timeout abort and status update.
    always_comb begin
        state_next   = state;
        tmo_cnt_next = tmo_cnt;
        mon_d_next   = MonDReg;
        mon_a_next   = MonAReg;
        ready_next   = monitor_ready;
        error_next   = monitor_error;

        if (state == IDLE) begin
            tmo_cnt_next = '0;
            if (any_strobe) begin
                if (!debugack) begin
                    error_next = 1'b1;
                end else begin
                    ready_next = 1'b0;
                    error_next = 1'b0;
                    if (take_action_ocimem_a) begin
                        mon_a_next = jdo[17+ADDR_W-1:17];
                        // An address-only load has nothing to wait for, so it
                        // reports ready again immediately.
                        if (jdo[34]) begin
                            state_next = RD_REQ;
                        end else begin
                            ready_next = 1'b1;
                        end
                    end else if (take_action_ocimem_b) begin
                        mon_d_next = jdo[34:3];
                        state_next = WR_REQ;
                    end else begin
                        state_next = RD_REQ;
                    end
                end
            end
        end else begin
            // A strobe arriving mid-access is refused but the access carries on.
            if (any_strobe) begin
                error_next = 1'b1;
            end
            if (rd_done || wr_done) begin
                state_next   = IDLE;
                tmo_cnt_next = '0;
                ready_next   = 1'b1;
                mon_a_next   = MonAReg + 1'b1;
                if (rd_done) begin
                    mon_d_next = mem_readdata;
                end
            end else if (tmo_cnt == TMO_LAST) begin
                state_next   = IDLE;
                tmo_cnt_next = '0;
                ready_next   = 1'b1;
                error_next   = 1'b1;
            end else begin
                if ((state == RD_REQ) && !mem_waitrequest) begin
                    state_next = RD_WAIT;
                end
                tmo_cnt_next = tmo_cnt + 1'b1;
            end
        end
    end

    // State and monitor registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            MonDReg       <= 32'd0;
            MonAReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            state         <= state_next;
            tmo_cnt       <= tmo_cnt_next;
            MonDReg       <= mon_d_next;
            MonAReg       <= mon_a_next;
            monitor_ready <= ready_next;
            monitor_error <= error_next;
        end
    end

endmodule

// File: tb/tb_clock_cpu_cpu_debug_mem_access.sv
// Self-checking bench: directed scenarios plus randomized commands against a
// transaction-level model of the monitor registers and a bench-owned memory.
module tb_clock_cpu_cpu_debug_mem_access;

    localparam int ADDR_W = 8;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic              debugack;
    logic [31:0]       MonDReg;
    logic [ADDR_W-1:0] MonAReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
    logic              mem_readdatavalid;
    logic              mem_waitrequest;

    clock_cpu_cpu_debug_mem_access #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .debugack                (debugack),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .mem_address             (mem_address),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_writedata           (mem_writedata),
        .mem_readdata            (mem_readdata),
        .mem_readdatavalid       (mem_readdatavalid),
        .mem_waitrequest         (mem_waitrequest)
    );

    always #5 clk = ~clk;

    int          errCount   = 0;
    int          checkCount = 0;
    logic [31:0] memArr [0:255];
    logic [7:0]  mAddr;
    logic [31:0] mData;
    logic        mReady;
    logic        mErr;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".MonAReg"}, 32'(MonAReg), 32'(mAddr));
        checkOutput({tag, ".MonDReg"}, MonDReg, mData);
        checkOutput({tag, ".ready"}, 32'(monitor_ready), 32'(mReady));
        checkOutput({tag, ".error"}, 32'(monitor_error), 32'(mErr));
        checkOutput({tag, ".idle_req"}, {30'd0, mem_read, mem_write}, 32'd0);
    endtask

    task automatic clearStrobes();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    // Issue one command at a negedge and play the memory slave until done.
    task automatic applyStimulus(input string tag, input logic [2:0] stb, input logic [37:0] j,
                                 input logic dbg, input int waits, input int lat,
                                 input bit noResp, input int injectAt,
                                 output int cycles, output int wrCycles);
        bit    isRead;
        bit    isWrite;
        bit    injected;
        bit    acc;
        int    w;
        int    l;
        string reqTag;
        cycles   = 0;
        wrCycles = 0;
        isRead   = 0;
        isWrite  = 0;
        injected = 0;
        acc      = 0;
        w        = waits;
        l        = lat;
        jdo                     = j;
        take_action_ocimem_a    = stb[0];
        take_action_ocimem_b    = stb[1];
        take_no_action_ocimem_a = stb[2];
        debugack                = dbg;
        if (stb != 3'b000) begin
            if (!dbg) begin
                mErr = 1'b1;
            end else begin
                mReady = 1'b0;
                mErr   = 1'b0;
                if (stb[0]) begin
                    mAddr = j[24:17];
                    if (j[34]) isRead = 1;
                    else mReady = 1'b1;
                end else if (stb[1]) begin
                    mData   = j[34:3];
                    isWrite = 1;
                end else begin
                    isRead = 1;
                end
            end
        end
        @(negedge clk);
        clearStrobes();
        debugack = 1'b1;
        reqTag   = isRead ? {tag, ".req_read"} : {tag, ".req_write"};
        if (isRead || isWrite) begin
            while (!monitor_ready && cycles < TMO + 8) begin
                mem_waitrequest   = 1'b0;
                mem_readdatavalid = 1'b0;
                mem_readdata      = $urandom;
                clearStrobes();
                if (cycles == injectAt) begin
                    {take_no_action_ocimem_a, take_action_ocimem_b, take_action_ocimem_a} = 3'($urandom_range(1, 7));
                    jdo      = {6'($urandom), $urandom};
                    injected = 1;
                end
                if (!acc) begin
                    checkOutput({tag, ".req_addr"}, 32'(mem_address), 32'(mAddr));
                    checkOutput(reqTag, {30'd0, mem_read, mem_write}, isRead ? 32'd2 : 32'd1);
                    if (isWrite) checkOutput({tag, ".wdata"}, mem_writedata, mData);
                    if (mem_write) wrCycles++;
                    if (w > 0 || (isWrite && noResp)) begin
                        mem_waitrequest = 1'b1;
                        if (w > 0) w--;
                    end else begin
                        acc = 1;
                        if (isWrite) begin
                            memArr[mAddr] = mData;
                        end else if (!noResp && l == 0) begin
                            mem_readdatavalid = 1'b1;
                            mem_readdata      = memArr[mAddr];
                        end
                    end
                end else if (isRead && !noResp && l > 0) begin
                    l--;
                    if (l == 0) begin
                        mem_readdatavalid = 1'b1;
                        mem_readdata      = memArr[mAddr];
                    end
                end
                @(negedge clk);
                cycles++;
            end
            clearStrobes();
            mem_waitrequest   = 1'b0;
            mem_readdatavalid = 1'b0;
            checkOutput({tag, ".done_in_bound"}, 32'(monitor_ready), 32'd1);
            mReady = 1'b1;
            if (noResp) begin
                mErr = 1'b1;
            end else begin
                if (isRead) mData = memArr[mAddr];
                mAddr = mAddr + 8'd1;
            end
            if (injected) mErr = 1'b1;
        end
        checkState(tag);
    endtask

    initial begin
        int          cyc;
        int          wr;
        logic [37:0] j;
        for (int i = 0; i < 256; i++) memArr[i] = $urandom;
        reset             = 1'b1;
        jdo               = '0;
        debugack          = 1'b1;
        mem_readdata      = '0;
        mem_readdatavalid = 1'b0;
        mem_waitrequest   = 1'b0;
        clearStrobes();
        mAddr  = 8'd0;
        mData  = 32'd0;
        mReady = 1'b1;
        mErr   = 1'b0;
        repeat (3) @(negedge clk);
        checkState("reset");
        reset = 1'b0;
        @(negedge clk);

        // Read at 0x10 with one cycle of read latency.
        memArr[8'h10] = 32'hDEADBEEF;
        j = '0; j[24:17] = 8'h10; j[34] = 1'b1;
        applyStimulus("rd10", 3'b001, j, 1'b1, 0, 1, 0, -1, cyc, wr);
        checkOutput("rd10.data_const", MonDReg, 32'hDEADBEEF);
        checkOutput("rd10.addr_const", 32'(MonAReg), 32'h11);

        // Load 0xFF, then a write stalled for three cycles wraps the address.
        j = '0; j[24:17] = 8'hFF;
        applyStimulus("ldFF", 3'b001, j, 1'b1, 0, 0, 0, -1, cyc, wr);
        j = '0; j[34:3] = 32'h12345678;
        applyStimulus("wrFF", 3'b010, j, 1'b1, 3, 0, 0, -1, cyc, wr);
        checkOutput("wrFF.write_cycles", 32'(wr), 32'd4);
        checkOutput("wrFF.mem", memArr[8'hFF], 32'h12345678);
        checkOutput("wrFF.addr_wrap", 32'(MonAReg), 32'h00);

        // Read that never returns data must abort after the timeout.
        applyStimulus("tmo", 3'b100, '0, 1'b1, 0, 0, 1, -1, cyc, wr);
        checkOutput("tmo.cycles", 32'(cyc), 32'(TMO));

        // Command while the CPU is not halted is refused.
        applyStimulus("nodbg", 3'b100, '0, 1'b0, 0, 0, 0, -1, cyc, wr);
        applyStimulus("dbgok", 3'b100, '0, 1'b1, 1, 0, 0, -1, cyc, wr);

        // Strobe during RD_WAIT is refused without disturbing the read.
        applyStimulus("rdwait_stb", 3'b100, '0, 1'b1, 0, 3, 0, 2, cyc, wr);

        // Priority with all strobes together.
        j = {6'($urandom), $urandom}; j[34] = 1'b1;
        applyStimulus("prio", 3'b111, j, 1'b1, 1, 1, 0, -1, cyc, wr);

        // Reset in the middle of a stalled write.
        j = {6'($urandom), $urandom};
        take_action_ocimem_b = 1'b1;
        jdo = j;
        @(negedge clk);
        clearStrobes();
        mem_waitrequest = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstwr.write_before", 32'(mem_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        mAddr = 8'd0; mData = 32'd0; mReady = 1'b1; mErr = 1'b0;
        checkState("rstwr.in_reset");
        @(negedge clk);
        reset           = 1'b0;
        mem_waitrequest = 1'b0;
        mem_readdatavalid = 1'b1;
        mem_readdata    = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        mem_readdatavalid = 1'b0;
        checkState("rstwr.after");

        // Randomized commands.
        for (int n = 0; n < 40; n++) begin
            logic [2:0] stb;
            logic       dbg;
            int         inj;
            stb = 3'($urandom_range(1, 7));
            dbg = ($urandom_range(0, 7) != 0);
            j   = {6'($urandom), $urandom};
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            applyStimulus("rand", stb, j, dbg, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 9) == 0), inj, cyc, wr);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/clock_cpu_cpu_debug_mem_access.md
CLOCK_CPU_CPU_DEBUG_MEM_ACCESS -- requirements
Module: clock_CPU_cpu_debug_mem_access

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the debug memory port.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles an access may stall before abort.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  async active-high reset.
REQ-006 SHALL have port jdo  input  38  JTAG data word, valid in the cycle a take_* strobe is high.
REQ-007 SHALL have ports take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a  input  1 each  single-cycle command strobes.
REQ-008 SHALL have port debugack  input  1  CPU is halted in debug mode.
REQ-009 SHALL have port MonDReg  output  32  monitor data register.
REQ-010 SHALL have port MonAReg  output  ADDR_W  monitor word-address register.
REQ-011 SHALL have ports monitor_ready, monitor_error  output  1 each  status flags.
REQ-012 SHALL have ports mem_address (ADDR_W), mem_read (1), mem_write (1), mem_writedata (32)  output  memory master request.
REQ-013 SHALL have ports mem_readdata (32), mem_readdatavalid (1), mem_waitrequest (1)  input  memory master response.

Function
REQ-014 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ; commands are accepted only in IDLE.
REQ-015 SHALL, on take_action_ocimem_a, load MonAReg <= jdo[17+ADDR_W-1:17]; if jdo[34]=1, also start a read at the new address (IDLE->RD_REQ next cycle).
REQ-016 SHALL, on take_action_ocimem_b, load MonDReg <= jdo[34:3] and start a write at current MonAReg (IDLE->WR_REQ).
REQ-017 SHALL, on take_no_action_ocimem_a, start a read at current MonAReg (IDLE->RD_REQ).
REQ-018 SHALL apply priority take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a when strobes coincide; lower-priority strobes are dropped silently.
REQ-019 SHALL, for any strobe while debugack=0, perform no register load or access and set monitor_error=1.
REQ-020 SHALL, for any strobe while not in IDLE, drop it and set monitor_error=1 without disturbing the access in flight.
REQ-021 SHALL clear monitor_ready and monitor_error in the cycle a command is accepted.
REQ-022 SHALL drive mem_address=MonAReg; mem_read=1 only in RD_REQ; mem_write=1 and mem_writedata=MonDReg only in WR_REQ.
REQ-023 SHALL hold request signals stable while mem_waitrequest=1; request is accepted on the first cycle with mem_waitrequest=0.
REQ-024 SHALL move RD_REQ->RD_WAIT on acceptance, unless mem_readdatavalid=1 in that same cycle, in which case the read completes directly.
REQ-025 SHALL, on read completion, load MonDReg <= mem_readdata, return to IDLE, set monitor_ready=1.
REQ-026 SHALL, on write acceptance, return to IDLE and set monitor_ready=1.
REQ-027 SHALL increment MonAReg by 1 modulo 2^ADDR_W on every successful completion (2^ADDR_W-1 wraps to 0).
REQ-028 SHALL count cycles spent outside IDLE; the counter is cleared on entry to IDLE.
REQ-029 SHALL, when the counter reaches TIMEOUT_CYCLES, deassert mem_read/mem_write, go to IDLE, set monitor_error=1 and monitor_ready=1, leave MonAReg and MonDReg unchanged.
REQ-030 SHALL ignore mem_readdatavalid in IDLE, WR_REQ and RD_REQ-before-acceptance.

Reset
REQ-031 SHALL, while reset=1, force state IDLE, MonDReg=0, MonAReg=0, monitor_ready=1, monitor_error=0, mem_read=0, mem_write=0, timeout counter=0.
REQ-032 SHALL abort any in-flight access on reset assertion with no completion side effects after release.

Verification
REQ-033 SHALL cover: debugack=1, take_action_ocimem_a with jdo[24:17]=0x10, jdo[34]=1, zero-wait memory returning 0xDEADBEEF one cycle after accept -> MonDReg=0xDEADBEEF, MonAReg=0x11, monitor_ready=1.
REQ-034 SHALL cover: MonAReg=0xFF, take_action_ocimem_b with jdo[34:3]=0x12345678, waitrequest high 3 cycles -> mem_write held 4 cycles at address 0xFF, data 0x12345678; MonAReg=0x00 afterwards.
REQ-035 SHALL cover: read with mem_readdatavalid never asserted -> mem_read low and monitor_error=1, monitor_ready=1 exactly TIMEOUT_CYCLES cycles after command accept; MonAReg unchanged.
REQ-036 SHALL cover: debugack=0, take_no_action_ocimem_a -> no mem_read, monitor_error=1; then debugack=1 and valid command -> monitor_error=0.
REQ-037 SHALL cover: second strobe during RD_WAIT, and reset asserted mid-WR_REQ -> first access completes unaffected with monitor_error=1; after reset all outputs at REQ-031 values and no late completion.
